// File: rtl/logic_axi4_stream_if.sv
// ============================================================================
// logic_axi4_stream_if
// ----------------------------------------------------------------------------
// Purpose : AXI4-Stream bundle shared by stream blocks. A width parameter of 0
//           means "field not used"; the signal is then kept at 1 bit so the
//           bundle always elaborates, and the consumer ignores it.
// Ports   : none (signals only)
//   rx modport : block receives a stream  (tvalid + payload in, tready out)
//   tx modport : block drives a stream    (tvalid + payload out, tready in)
// ============================================================================
interface logic_axi4_stream_if #(
    parameter int TDATA_BYTES = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TUSER_WIDTH = 1,
    parameter int TID_WIDTH   = 1
) ();
    localparam int KEEP_W = (TDATA_BYTES > 0) ? TDATA_BYTES : 1;
    localparam int DATA_W = KEEP_W * 8;
    localparam int DEST_W = (TDEST_WIDTH > 0) ? TDEST_WIDTH : 1;
    localparam int USER_W = (TUSER_WIDTH > 0) ? TUSER_WIDTH : 1;
    localparam int ID_W   = (TID_WIDTH   > 0) ? TID_WIDTH   : 1;

    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic [KEEP_W-1:0] tstrb;
    logic              tlast;
    logic [USER_W-1:0] tuser;
    logic [DEST_W-1:0] tdest;
    logic [ID_W-1:0]   tid;

    modport rx (
        input  tvalid, tdata, tkeep, tstrb, tlast, tuser, tdest, tid,
        output tready
    );

    modport tx (
        output tvalid, tdata, tkeep, tstrb, tlast, tuser, tdest, tid,
        input  tready
    );
endinterface

// File: rtl/logic_axi4_stream_split_buffered.sv
// ============================================================================
// logic_axi4_stream_split_buffered
// ----------------------------------------------------------------------------
// Purpose : AXI4-Stream broadcast splitter. Each accepted rx beat is copied
//           into a private FIFO for every output selected by the packet mask,
//           so a slow consumer only stalls rx once its own FIFO is full.
//           The mask is sampled from `enable` on the first beat of a packet
//           and held until that packet's tlast has been accepted.
// Ports   :
//   aclk      in   clock, rising edge
//   areset_n  in   asynchronous active-low reset
//   enable    in   [OUTPUTS] per-output enable, sampled at packet start
//   active    out  [OUTPUTS] mask latched for the packet in flight
//   busy      out  packet open or any FIFO holding beats
//   rx        rx modport, input stream
//   tx        tx modport array [OUTPUTS], output streams
// ============================================================================
module logic_axi4_stream_split_buffered #(
    parameter int OUTPUTS     = 2,
    parameter int DEPTH       = 4,
    parameter int TDATA_BYTES = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TUSER_WIDTH = 1,
    parameter int TID_WIDTH   = 1,
    parameter bit USE_TLAST   = 1'b1,
    parameter bit USE_TKEEP   = 1'b1,
    parameter bit USE_TSTRB   = 1'b1
) (
    input  logic               aclk,
    input  logic               areset_n,
    input  logic [OUTPUTS-1:0] enable,
    output logic [OUTPUTS-1:0] active,
    output logic               busy,
    logic_axi4_stream_if.rx    rx,
    logic_axi4_stream_if.tx    tx [OUTPUTS]
);
    localparam int KEEP_W = (TDATA_BYTES > 0) ? TDATA_BYTES : 1;
    localparam int DATA_W = KEEP_W * 8;
    localparam int DEST_W = (TDEST_WIDTH > 0) ? TDEST_WIDTH : 1;
    localparam int USER_W = (TUSER_WIDTH > 0) ? TUSER_WIDTH : 1;
    localparam int ID_W   = (TID_WIDTH   > 0) ? TID_WIDTH   : 1;
    localparam int AW     = $clog2(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] tdata;
        logic [KEEP_W-1:0] tkeep;
        logic [KEEP_W-1:0] tstrb;
        logic              tlast;
        logic [USER_W-1:0] tuser;
        logic [DEST_W-1:0] tdest;
        logic [ID_W-1:0]   tid;
    } beat_t;

    logic               r_open;
    logic [OUTPUTS-1:0] r_active;

    logic [OUTPUTS-1:0] w_sel;
    logic [OUTPUTS-1:0] w_full;
    logic [OUTPUTS-1:0] w_empty;
    logic [OUTPUTS-1:0] w_push;
    logic               w_ready;
    logic               w_accept;
    logic               w_last;
    beat_t              w_beat;

    // While a packet is open the latched mask steers it; otherwise the live
    // enable decides where the opening beat goes.
    assign w_sel = r_open ? r_active : enable;

    // Only selected outputs can block rx, and only by being full. No bypass:
    // a full FIFO blocks even if it is popping this cycle.
    assign w_ready  = &(~w_sel | ~w_full);
    assign rx.tready = w_ready;
    assign w_accept = rx.tvalid & w_ready;
    assign w_last   = USE_TLAST ? rx.tlast : 1'b1;
    assign w_push   = {OUTPUTS{w_accept}} & w_sel;

    assign w_beat.tdata = rx.tdata;
    assign w_beat.tkeep = rx.tkeep;
    assign w_beat.tstrb = rx.tstrb;
    assign w_beat.tlast = rx.tlast;
    assign w_beat.tuser = rx.tuser;
    assign w_beat.tdest = rx.tdest;
    assign w_beat.tid   = rx.tid;

    // Packet tracking. A single-beat packet still refreshes the mask.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_open   <= 1'b0;
            r_active <= '0;
        end else if (w_accept) begin
            if (!r_open) begin
                r_active <= enable;
            end
            r_open <= !w_last;
        end
    end

    assign active = r_active;
    assign busy   = r_open | ~(&w_empty);

    for (genvar gi = 0; gi < OUTPUTS; gi++) begin : g_out
        logic [AW:0] r_wr_ptr;
        logic [AW:0] r_rd_ptr;
        beat_t       r_mem [DEPTH];
        beat_t       w_head;
        logic        w_pop;

        // Pointers carry one extra wrap bit to tell full from empty.
        assign w_empty[gi] = (r_wr_ptr == r_rd_ptr);
        assign w_full[gi]  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                             (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
        assign w_pop       = !w_empty[gi] && tx[gi].tready;

        always_ff @(posedge aclk or negedge areset_n) begin
            if (!areset_n) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push[gi]) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
            end
        end

        // Payload storage is deliberately left out of reset.
        always_ff @(posedge aclk) begin
            if (w_push[gi]) begin
                r_mem[r_wr_ptr[AW-1:0]] <= w_beat;
            end
        end

        // Head is read combinationally so a beat is visible the cycle after
        // it was written and stays stable until popped.
        assign w_head = r_mem[r_rd_ptr[AW-1:0]];

        assign tx[gi].tvalid = !w_empty[gi];
        assign tx[gi].tdata  = (TDATA_BYTES > 0) ? w_head.tdata : '0;
        assign tx[gi].tkeep  = (TDATA_BYTES == 0) ? '0 : (USE_TKEEP ? w_head.tkeep : '1);
        assign tx[gi].tstrb  = (TDATA_BYTES == 0) ? '0 : (USE_TSTRB ? w_head.tstrb : '1);
        assign tx[gi].tlast  = USE_TLAST ? w_head.tlast : 1'b1;
        assign tx[gi].tuser  = (TUSER_WIDTH > 0) ? w_head.tuser : '0;
        assign tx[gi].tdest  = (TDEST_WIDTH > 0) ? w_head.tdest : '0;
        assign tx[gi].tid    = (TID_WIDTH   > 0) ? w_head.tid   : '0;
    end
endmodule
